button_debounce: RTL
====================

Name: button_debounce

Overview:
Input-side counterpart to the board's LED outputs. Takes one raw, asynchronous push-button pad and synchronises it to the clock. Filters contact bounce with a counter-based stability check, then produces a clean level plus single-cycle press, release and long-press event pulses and a press counter. Sits in the system top beside the LED logic and feeds the peripheral/control logic.

Parameters:
CLK_FREQ, 80000000, clock frequency in Hz.
DEBOUNCE_MS, 10, required stable time in ms. DB_CNT = CLK_FREQ/1000*DEBOUNCE_MS cycles; must be >= 2.
LONG_PRESS_MS, 1000, hold time in ms for a long press. LP_CNT = CLK_FREQ/1000*LONG_PRESS_MS cycles; must be > DB_CNT.
ACTIVE_LOW, 1, 1 = pad reads 0 when pressed; 0 = pad reads 1 when pressed.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
btn_in  input  1  raw button pad, asynchronous to clk.
btn_level  output  1  debounced level, 1 = pressed.
press_pulse  output  1  one-cycle pulse on an accepted press.
release_pulse  output  1  one-cycle pulse on an accepted release.
long_press  output  1  one-cycle pulse when a press has been held for LP_CNT cycles.
press_count  output  8  number of accepted presses, modulo 256.

Behaviour:
- Synchroniser: 2-FF chain on btn_in, then polarity normalisation to s (1 = pressed). The chain resets to the released level. No logic reads btn_in before the second flop.
- All outputs are registered. Reset values: btn_level=0, all pulses=0, press_count=0, state=IDLE, all counters=0.
- Counters: db_cnt is sized clog2(DB_CNT); hold_cnt is sized clog2(LP_CNT+1) and saturates at LP_CNT.
- FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE.
  - IDLE: if s=1, go to DB_PRESS with db_cnt<=0.
  - DB_PRESS: if s=0, return to IDLE. The bounce is rejected with no output activity. Otherwise db_cnt++. When db_cnt==DB_CNT-1 and s=1: go to HELD, btn_level<=1, press_pulse<=1 for one cycle, press_count++ (wraps 255->0), hold_cnt<=0.
  - HELD: hold_cnt++ (saturating). If s=0, go to DB_RELEASE with db_cnt<=0.
  - DB_RELEASE: hold_cnt keeps incrementing. If s=1, return to HELD; btn_level stays 1, no pulse, hold_cnt is not cleared. Otherwise db_cnt++. When db_cnt==DB_CNT-1 and s=0: go to IDLE, btn_level<=0, release_pulse<=1 for one cycle.
- long_press:
  - Asserts for exactly one cycle when hold_cnt reaches LP_CNT-1 while in HELD or DB_RELEASE. This is LP_CNT cycles after press_pulse.
  - Fires at most once per accepted press; saturation prevents a repeat.
  - If the release is accepted before that point, long_press never fires for that press.
- Latency: let N0 be the first clk edge sampling the new stable pad level. press_pulse/release_pulse and the btn_level change register at edge N0+DB_CNT+2.
- Simultaneous events: press_pulse and release_pulse can never be high in the same cycle. long_press may coincide with no other pulse, because LP_CNT > DB_CNT.
- Any s glitch shorter than DB_CNT cycles restarts qualification: it falls back to IDLE or HELD, and the next transition attempt starts from db_cnt=0.
- Reset mid-operation clears everything immediately on the next edge; no pulses are emitted for the aborted event. If the button is held through reset deassertion, it is qualified as a fresh press: press_pulse fires DB_CNT+2 cycles after the first post-reset edge.

Test Plan:
(Bench parameters: CLK_FREQ=10000, DEBOUNCE_MS=1 (DB_CNT=10), LONG_PRESS_MS=5 (LP_CNT=50), ACTIVE_LOW=1.)
1. Reset, pad=1 for 20 cycles -> btn_level=0, all pulses 0, press_count=0.
2. Pad driven 0 and held from edge N0 -> press_pulse high for exactly one cycle at N0+12, btn_level=1 from then, press_count=1. Pad back to 1 at M0 -> release_pulse one cycle at M0+12, btn_level=0.
3. Bounce: pad toggles 0/1 every 3 cycles for 40 cycles, then settles at 1 -> no pulses, btn_level=0, press_count unchanged.
4. Press held 80 cycles with a 4-cycle release glitch at cycle 30 -> one press_pulse, no release_pulse until the final release, and long_press fires exactly once, 50 cycles after press_pulse.
5. Press held 30 cycles then released -> press_pulse then release_pulse; long_press never asserts.
6. 257 clean presses -> press_count=1 at the end (wrap). Reset asserted mid-DB_PRESS -> no press_pulse. Pad held low across reset deassert -> press_pulse 12 cycles after the first post-reset edge.

Source files
------------

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Cleans up one raw push-button pad for the control logic. The pad goes through
// a two-flop synchroniser, is normalised so that 1 always means "pressed", and
// is then qualified by a counter-based stability check. A four-state FSM
// produces a clean debounced level, one-cycle press / release / long-press
// pulses and a wrapping 8-bit press counter. All outputs are registered.
//
// Parameters
//   CLK_FREQ      clock frequency in Hz
//   DEBOUNCE_MS   stable time before a level change is accepted, in ms
//                 (DB_CNT = CLK_FREQ/1000*DEBOUNCE_MS cycles, must be >= 2)
//   LONG_PRESS_MS hold time for a long press, in ms
//                 (LP_CNT = CLK_FREQ/1000*LONG_PRESS_MS cycles, must exceed DB_CNT)
//   ACTIVE_LOW    1: pad reads 0 when pressed, 0: pad reads 1 when pressed
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   btn_in         raw button pad, asynchronous to clk
//   btn_level      debounced level, 1 = pressed
//   press_pulse    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//   long_press     one-cycle pulse LP_CNT cycles after press_pulse, if still held
//   press_count    accepted presses, modulo 256
//
// Latency: with N0 the first edge that samples a new stable pad level, the
// matching pulse and btn_level change register at edge N0 + DB_CNT + 2.
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int CLK_FREQ      = 80000000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int DB_CNT = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LP_CNT = CLK_FREQ / 1000 * LONG_PRESS_MS;

  localparam int DB_W   = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam int HOLD_W = $clog2(LP_CNT + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CNT - 1);
  localparam logic [HOLD_W-1:0] LP_LAST  = HOLD_W'(LP_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LP_CNT);

  // Synchroniser flops idle at the electrical "released" level so that a
  // reset never looks like a transition on the pad.
  localparam logic [1:0] SYNC_IDLE = {2{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              s;
  logic              in_hold;
  logic              release_accept;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Nothing downstream looks at btn_in or sync_q[0];
  // only the second flop feeds the qualification logic.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two-stage chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= SYNC_IDLE;
    end else begin
      sync_q <= {sync_q[0], btn_in};
    end
  end

  // Polarity-normalised, synchronised pad: 1 = pressed.
  assign s = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // The hold timer runs while the button is (provisionally) down.
  assign in_hold = (state == HELD) || (state == DB_RELEASE);

  // Release is accepted on this edge; used to keep long_press from ever
  // sharing a cycle with release_pulse.
  assign release_accept = (state == DB_RELEASE) && !s && (db_cnt == DB_LAST);

  // ---------------------------------------------------------------------------
  // Qualification FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      // NOTE: pulses default low at the top of the block; a later assignment in
      // the same block overrides it, which is what makes them one cycle wide.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;

      // Saturating hold timer: stopping at LP_CNT guarantees the LP_LAST
      // compare below can only match once per accepted press.
      if (in_hold && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      // Registered one edge after hold_cnt reaches LP_CNT-1, i.e. exactly
      // LP_CNT cycles after press_pulse.
      if (in_hold && (hold_cnt == LP_LAST) && !release_accept) begin
        long_press <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (s) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
          end
        end

        DB_PRESS: begin
          if (!s) begin
            // Bounce: drop back silently.
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            hold_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        HELD: begin
          if (!s) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end
        end

        DB_RELEASE: begin
          if (s) begin
            // Release glitch: still pressed, hold timer keeps its value.
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
